load_mem_unit: RTL

- Downstream consumer of the load buffer in the Tomasulo LC-3b datapath.
- Takes the oldest ready load entry (effective address already computed), pops it, performs the D-cache read, and aligns/sign-extends the result.
- Requests the CDB and broadcasts the value tagged with the load's ROB entry.
- Handles flush from branch mispredict/exception, including a read already in flight to the cache.

---
 rtl/lc3b_types.sv | 20 ++
 rtl/load_mem_unit_if.sv | 34 +++
 rtl/load_align.sv | 19 +
 rtl/load_mem_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types plus the load memory unit state encoding
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_rob_addr;

  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     data;
  } CDB;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    BCAST
  } lmu_state;

endpackage

// File: rtl/load_mem_unit_if.sv
// rtl/load_mem_unit_if.sv - load buffer, D-cache and CDB signals of the load memory unit
interface load_mem_unit_if #(
  parameter int data_width = 16
);
  import lc3b_types::*;

  logic                  flush;
  logic                  lb_valid;
  logic [data_width-1:0] lb_addr;
  lc3b_rob_addr          lb_dest;
  logic                  lb_byte;
  logic                  st_conflict;
  logic                  lb_RE;
  logic                  dmem_read;
  logic [data_width-1:0] dmem_address;
  logic [data_width-1:0] dmem_rdata;
  logic                  dmem_resp;
  logic                  cdb_req;
  logic                  cdb_grant;
  CDB                    CDB_out;

  modport master (
    input  flush, lb_valid, lb_addr, lb_dest, lb_byte, st_conflict,
           dmem_rdata, dmem_resp, cdb_grant,
    output lb_RE, dmem_read, dmem_address, cdb_req, CDB_out
  );

  modport slave (
    output flush, lb_valid, lb_addr, lb_dest, lb_byte, st_conflict,
           dmem_rdata, dmem_resp, cdb_grant,
    input  lb_RE, dmem_read, dmem_address, cdb_req, CDB_out
  );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - selects LDR word or sign-extended LDB byte from a cache read word
module load_align #(
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] rdata,
  input  logic                  addr0,
  input  logic                  byte_sel,
  output logic [data_width-1:0] aligned
);

  logic [7:0] byte_val;

  // Odd byte addresses take the upper byte; bytes are sign-extended to a full word
  always_comb begin
    byte_val = addr0 ? rdata[15:8] : rdata[7:0];
    aligned  = byte_sel ? {{(data_width-8){byte_val[7]}}, byte_val} : rdata;
  end

endmodule

// File: rtl/load_mem_unit.sv
// rtl/load_mem_unit.sv - pops the load buffer, reads the D-cache and broadcasts on the CDB
module load_mem_unit
  import lc3b_types::*;
#(
  parameter int data_width = 16
) (
  input logic              clk,
  input logic              reset,
  load_mem_unit_if.master  bus
);

  lmu_state              state, next_state;
  logic [data_width-1:0] addr_q;
  lc3b_rob_addr          dest_q;
  logic                  byte_q;
  lc3b_word              data_q;
  logic [data_width-1:0] aligned;
  logic                  pop, rd, req, bcast;

  load_align #(.data_width(data_width)) u_align (
    .rdata    (bus.dmem_rdata),
    .addr0    (addr_q[0]),
    .byte_sel (byte_q),
    .aligned  (aligned)
  );

  // Next state and strobes; a read stays asserted through DRAIN since the cache cannot drop a request
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    rd         = 1'b0;
    req        = 1'b0;
    bcast      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.lb_valid && !bus.st_conflict && !bus.flush) begin
          pop        = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        rd = 1'b1;
        if (bus.dmem_resp) next_state = bus.flush ? IDLE : BCAST;
        else if (bus.flush) next_state = DRAIN;
      end
      DRAIN: begin
        rd = 1'b1;
        if (bus.dmem_resp) next_state = IDLE;
      end
      BCAST: begin
        req = 1'b1;
        if (bus.flush) next_state = IDLE;
        else if (bus.cdb_grant) begin
          bcast      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (reset) begin
      pop   = 1'b0;
      rd    = 1'b0;
      req   = 1'b0;
      bcast = 1'b0;
    end
  end

  // State register, popped entry capture and aligned result capture on a clean response
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      dest_q <= '0;
      byte_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        addr_q <= bus.lb_addr;
        dest_q <= bus.lb_dest;
        byte_q <= bus.lb_byte;
      end
      if (state == READ && bus.dmem_resp && !bus.flush) data_q <= aligned;
    end
  end

  assign bus.lb_RE         = pop;
  assign bus.dmem_read     = rd;
  assign bus.dmem_address  = addr_q;
  assign bus.cdb_req       = req;
  assign bus.CDB_out.valid = bcast;
  assign bus.CDB_out.tag   = dest_q;
  assign bus.CDB_out.data  = data_q;

endmodule
